gray_switch_debouncer: RTL and testbench

Input conditioning stage between the four physical Gray-coded switch pins (`ag`, `bg`, `cg`, `dg`) and the Gray-to-binary decoder. It synchronizes the asynchronous pins to `clk` and rejects contact bounce with a shared stability counter. It presents a clean, registered Gray vector plus a one-cycle change strobe and change mask. Its output replaces the bare two-flop synchronizers on the decoder input.

---
 rtl/gray_switch_debouncer.sv | 139 +++++++++++++
 tb/tb_gray_switch_debouncer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gray_switch_debouncer.sv
// gray_switch_debouncer
// Conditions the Gray-coded switch pins for the decoder. Each pin passes
// through a two-flop synchronizer, and one shared stability counter then
// debounces the whole vector. A value is accepted only after it has been
// seen unchanged for DEBOUNCE_CYCLES consecutive edges. Any bit that moves
// restarts the count.
module gray_switch_debouncer #(
    parameter int N_BITS          = 4,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] sw_raw,
    output logic [N_BITS-1:0] sw_stable,
    output logic              sw_valid,
    output logic              changed,
    output logic [N_BITS-1:0] changed_mask,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        COUNT = 2'd2
    } state_t;

    logic [N_BITS-1:0] ff1_r;
    logic [N_BITS-1:0] sync_q_r;
    state_t            state_r,     state_s;
    logic [N_BITS-1:0] candidate_r, candidate_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic [N_BITS-1:0] stable_r,    stable_s;
    logic              valid_r,     valid_s;
    logic              changed_r,   changed_s;
    logic [N_BITS-1:0] mask_r,      mask_s;

    // Two-flop synchronizer that brings the asynchronous pins into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_r    <= {N_BITS{1'b0}};
            sync_q_r <= {N_BITS{1'b0}};
        end else begin
            ff1_r    <= sw_raw;
            sync_q_r <= ff1_r;
        end
    end

    // Next-state and next-output logic for the debounce FSM
    always_comb begin
        state_s     = state_r;
        candidate_s = candidate_r;
        cnt_s       = cnt_r;
        stable_s    = stable_r;
        valid_s     = valid_r;
        changed_s   = 1'b0;
        mask_s      = mask_r;
        case (state_r)
            INIT: begin
                // First acceptance after reset sets sw_valid without raising a change strobe
                if (sync_q_r != candidate_r) begin
                    candidate_s = sync_q_r;
                    cnt_s       = CNT_ONE;
                end else if (cnt_r == CNT_LAST) begin
                    stable_s = candidate_r;
                    valid_s  = 1'b1;
                    cnt_s    = CNT_ZERO;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            IDLE: begin
                if (sync_q_r != stable_r) begin
                    candidate_s = sync_q_r;
                    cnt_s       = CNT_ONE;
                    state_s     = COUNT;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            COUNT: begin
                // When the input bounces back to the accepted value, drop the candidate
                if (sync_q_r == stable_r) begin
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                end else if (sync_q_r != candidate_r) begin
                    candidate_s = sync_q_r;
                    cnt_s       = CNT_ONE;
                end else if (cnt_r == CNT_LAST) begin
                    stable_s  = candidate_r;
                    changed_s = 1'b1;
                    mask_s    = stable_r ^ candidate_r;
                    cnt_s     = CNT_ZERO;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                // Recover from an illegal encoding by starting a fresh acquisition
                state_s = INIT;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; reset discards any partially counted value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= INIT;
            candidate_r <= {N_BITS{1'b0}};
            cnt_r       <= CNT_ZERO;
            stable_r    <= {N_BITS{1'b0}};
            valid_r     <= 1'b0;
            changed_r   <= 1'b0;
            mask_r      <= {N_BITS{1'b0}};
        end else begin
            state_r     <= state_s;
            candidate_r <= candidate_s;
            cnt_r       <= cnt_s;
            stable_r    <= stable_s;
            valid_r     <= valid_s;
            changed_r   <= changed_s;
            mask_r      <= mask_s;
        end
    end

    assign sw_stable    = stable_r;
    assign sw_valid     = valid_r;
    assign changed      = changed_r;
    assign changed_mask = mask_r;
    assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_gray_switch_debouncer.sv
// Testbench for gray_switch_debouncer with DEBOUNCE_CYCLES=4.
// The stimulus pushes the expected acceptance events (the first valid after
// reset, or a change strobe) into a queue. A negedge monitor pops and
// compares each event when the DUT presents it.
module tb_gray_switch_debouncer;

    localparam int N   = 4;
    localparam int DEB = 4;

    typedef struct packed {
        logic        is_chg;
        logic [3:0]  val;
        logic [3:0]  mask;
        logic [31:0] cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_stable;
    logic         sw_valid;
    logic         changed;
    logic [N-1:0] changed_mask;
    logic         busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;
    logic        prev_valid = 1'b0;
    ev_t         exp_q[$];
    logic [31:0] t;

    gray_switch_debouncer #(.N_BITS(N), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(sw_stable),
        .sw_valid(sw_valid), .changed(changed), .changed_mask(changed_mask),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Count the rising clock edges so that event timing can be checked
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_chg, input logic [3:0] val,
                        input logic [3:0] mask, input logic [31:0] at);
        ev_t e;
        e.is_chg = is_chg;
        e.val    = val;
        e.mask   = mask;
        e.cyc    = at;
        exp_q.push_back(e);
    endtask

    // Monitor: pops an expected event on every sw_valid rise or changed pulse
    always @(negedge clk) begin
        ev_t e;
        if ((sw_valid && !prev_valid) || changed) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: changed=%0b valid=%0b stable=%0h at cycle %0d",
                         changed, sw_valid, sw_stable, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind",   {31'd0, changed}, {31'd0, e.is_chg});
                chk("event_value",  {28'd0, sw_stable}, {28'd0, e.val});
                chk("event_mask",   {28'd0, changed_mask}, {28'd0, e.mask});
                chk("event_cycle",  cyc, e.cyc);
                chk("event_valid",  {31'd0, sw_valid}, 32'd1);
            end
        end
        prev_valid = sw_valid;
    end

    initial begin
        rst    = 1'b1;
        sw_raw = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_stable", {28'd0, sw_stable}, 32'd0);
        chk("reset_valid",  {31'd0, sw_valid}, 32'd0);
        chk("reset_changed", {31'd0, changed}, 32'd0);
        chk("reset_mask",   {28'd0, changed_mask}, 32'd0);
        chk("reset_busy",   {31'd0, busy}, 32'd1);

        // Release the reset with the pins held at 0000: valid on the fourth edge
        rst = 1'b0;
        t   = cyc;
        push(1'b0, 4'b0000, 4'b0000, t + 32'd4);
        repeat (3) @(negedge clk);
        chk("init_busy_high", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("init_busy_low",  {31'd0, busy}, 32'd0);
        chk("init_stable",    {28'd0, sw_stable}, 32'd0);

        // Reset with the pins at 1011: the value settles through the synchronizer and is counted again
        rst    = 1'b1;
        sw_raw = 4'b1011;
        #1;
        chk("rst2_valid", {31'd0, sw_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t   = cyc;
        push(1'b0, 4'b1011, 4'b0000, t + 32'd6);
        repeat (8) @(negedge clk);
        chk("rst2_stable", {28'd0, sw_stable}, 32'hb);
        chk("rst2_mask",   {28'd0, changed_mask}, 32'd0);

        // Return to 0000
        t      = cyc;
        sw_raw = 4'b0000;
        push(1'b1, 4'b0000, 4'b1011, t + 32'd6);
        repeat (8) @(negedge clk);

        // From 0000 to 0101, held
        t      = cyc;
        sw_raw = 4'b0101;
        push(1'b1, 4'b0101, 4'b0101, t + 32'd6);
        repeat (8) @(negedge clk);
        chk("c0101_stable", {28'd0, sw_stable}, 32'h5);

        // Back to 0000
        t      = cyc;
        sw_raw = 4'b0000;
        push(1'b1, 4'b0000, 4'b0101, t + 32'd6);
        repeat (8) @(negedge clk);

        // Bounce: 0001 for two cycles, then 0000 again
        t      = cyc;
        sw_raw = 4'b0001;
        repeat (2) @(negedge clk);
        sw_raw = 4'b0000;
        @(negedge clk);
        chk("bounce_busy_high", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        chk("bounce_busy_low", {31'd0, busy}, 32'd0);
        chk("bounce_stable",   {28'd0, sw_stable}, 32'd0);
        chk("bounce_mask_hold", {28'd0, changed_mask}, 32'h5);

        // 0011 for two cycles, then 0010 held: counting restarts on 0010
        t      = cyc;
        sw_raw = 4'b0011;
        push(1'b1, 4'b0010, 4'b0010, t + 32'd8);
        repeat (2) @(negedge clk);
        sw_raw = 4'b0010;
        repeat (8) @(negedge clk);
        chk("restart_stable", {28'd0, sw_stable}, 32'h2);

        // Reset in the middle of COUNT clears the outputs at once
        sw_raw = 4'b1111;
        repeat (4) @(negedge clk);
        chk("midcnt_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stable",  {28'd0, sw_stable}, 32'd0);
        chk("midrst_valid",   {31'd0, sw_valid}, 32'd0);
        chk("midrst_changed", {31'd0, changed}, 32'd0);
        chk("midrst_mask",    {28'd0, changed_mask}, 32'd0);
        chk("midrst_busy",    {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t   = cyc;
        push(1'b0, 4'b1111, 4'b0000, t + 32'd6);
        repeat (10) @(negedge clk);
        chk("final_stable", {28'd0, sw_stable}, 32'hf);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
